// File: rtl/icu_mc_pkg.sv
// Shared definitions for the sigma-delta input control unit.
//   - per-channel input mode encodings
//   - Manchester decoder states
//   - lower bound on the input synchroniser depth
package sdfm_icu_pkg;

  typedef enum logic [1:0] {
    MODE_SDCLK_RISE = 2'b00,
    MODE_SDCLK_FALL = 2'b01,
    MODE_MANCH      = 2'b10,
    MODE_INTCLK     = 2'b11
  } icu_mode_e;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } manch_state_e;

  localparam int unsigned MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/icu_mc_if.sv
// Pin/configuration/output bundle of the multi-channel input control unit.
//   DSDIN, SDCLK     : raw asynchronous modulator data/clock, one bit per channel
//   reg_inmode       : 2-bit mode per channel, channel i at [2i+1:2i]
//   reg_clkdiv       : DIV_W-bit divider / half-bit value per channel
//   err_clr          : one-cycle clear of err_manch per channel
//   sd_dsd/sd_strobe : sample bit and its one-cycle valid pulse
//   sd_clk_out       : generated modulator clock (internal-clock mode)
//   err_manch        : sticky Manchester loss-of-lock flag
interface icu_mc_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DIV_W = 4
) ();

  logic [NCH-1:0]       DSDIN;
  logic [NCH-1:0]       SDCLK;
  logic [2*NCH-1:0]     reg_inmode;
  logic [DIV_W*NCH-1:0] reg_clkdiv;
  logic [NCH-1:0]       err_clr;
  logic [NCH-1:0]       sd_dsd;
  logic [NCH-1:0]       sd_strobe;
  logic [NCH-1:0]       sd_clk_out;
  logic [NCH-1:0]       err_manch;

  modport slave (
    input  DSDIN, SDCLK, reg_inmode, reg_clkdiv, err_clr,
    output sd_dsd, sd_strobe, sd_clk_out, err_manch
  );

  modport master (
    output DSDIN, SDCLK, reg_inmode, reg_clkdiv, err_clr,
    input  sd_dsd, sd_strobe, sd_clk_out, err_manch
  );

endinterface

// File: rtl/icu_channel.sv
// One input control channel: synchronises DSDIN/SDCLK into clk and produces
// a one-cycle sample strobe with data in one of four modes
// (SDCLK rising, SDCLK falling, Manchester, internally generated clock).
//   clk, rst_n  : system clock, asynchronous active-low reset
//   dsdin, sdclk: raw asynchronous pins
//   mode, clkdiv: channel configuration
//   err_clr     : clear of the sticky Manchester error
//   sd_dsd, sd_strobe, sd_clk_out, err_manch : registered outputs
module icu_channel
  import sdfm_icu_pkg::*;
#(
  parameter int unsigned DIV_W       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dsdin,
  input  logic             sdclk,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] clkdiv,
  input  logic             err_clr,
  output logic             sd_dsd,
  output logic             sd_strobe,
  output logic             sd_clk_out,
  output logic             err_manch
);

  localparam int unsigned NS = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
  // mcnt must hold the timeout 2.5*(2^DIV_W); CW adds one bit for mcnt+1 compares
  localparam int unsigned MW = DIV_W + 2;
  localparam int unsigned CW = DIV_W + 3;

  logic [NS-1:0]    dsd_sync_q, dsd_sync_d, clk_sync_q, clk_sync_d;
  logic             dsd_dly_q, dsd_dly_d, clk_dly_q, clk_dly_d;
  icu_mode_e        mode_q, mode_d, mode_in;
  manch_state_e     st_q, st_d;
  logic             pend_q, pend_d, pend_dat_q, pend_dat_d;
  logic [DIV_W-1:0] divcnt_q, divcnt_d;
  logic             clkgen_q, clkgen_d;
  logic [MW-1:0]    mcnt_q, mcnt_d, mcnt_sat;
  logic             sd_dsd_q, sd_dsd_d, sd_strobe_q, sd_strobe_d, err_q, err_d;
  logic             err_set;
  logic             dsd_s, clk_s, rise, fall, dedge;
  logic [CW-1:0]    half, thr, lim, mcnt_inc;

  assign dsd_s = dsd_sync_q[NS-1];
  assign clk_s = clk_sync_q[NS-1];
  assign rise  = clk_s & ~clk_dly_q;
  assign fall  = ~clk_s & clk_dly_q;
  assign dedge = dsd_s ^ dsd_dly_q;

  assign mode_in  = icu_mode_e'(mode);
  assign half     = CW'(clkdiv) + CW'(1);
  assign thr      = half + (half >> 1);
  assign lim      = (half << 1) + (half >> 1);
  assign mcnt_inc = CW'(mcnt_q) + CW'(1);
  assign mcnt_sat = (mcnt_q == '1) ? mcnt_q : mcnt_q + MW'(1);

  always_comb begin
    dsd_sync_d  = {dsd_sync_q[NS-2:0], dsdin};
    clk_sync_d  = {clk_sync_q[NS-2:0], sdclk};
    dsd_dly_d   = dsd_s;
    clk_dly_d   = clk_s;
    mode_d      = mode_in;
    st_d        = st_q;
    pend_d      = 1'b0;
    pend_dat_d  = pend_dat_q;
    divcnt_d    = divcnt_q;
    clkgen_d    = clkgen_q;
    mcnt_d      = mcnt_q;
    sd_dsd_d    = sd_dsd_q;
    sd_strobe_d = 1'b0;
    err_set     = 1'b0;

    if (mode_in != mode_q) begin
      divcnt_d = '0;
      mcnt_d   = '0;
      clkgen_d = 1'b0;
      st_d     = HUNT;
    end else begin
      case (mode_q)
        // SDCLK modes: the edge cycle captures data, the strobe follows one cycle later
        MODE_SDCLK_RISE, MODE_SDCLK_FALL: begin
          if (pend_q) begin
            sd_dsd_d    = pend_dat_q;
            sd_strobe_d = 1'b1;
          end
          if ((mode_q == MODE_SDCLK_RISE) ? rise : fall) begin
            pend_d     = 1'b1;
            pend_dat_d = dsd_dly_q;
          end
        end
        MODE_INTCLK: begin
          if (divcnt_q >= clkdiv) begin
            divcnt_d = '0;
            clkgen_d = ~clkgen_q;
            if (!clkgen_q) begin
              sd_dsd_d    = dsd_s;
              sd_strobe_d = 1'b1;
            end
          end else begin
            divcnt_d = divcnt_q + DIV_W'(1);
          end
        end
        MODE_MANCH: begin
          mcnt_d = mcnt_sat;
          case (st_q)
            HUNT: begin
              if (dedge) begin
                sd_dsd_d    = dsd_s;
                sd_strobe_d = 1'b1;
                mcnt_d      = '0;
                st_d        = LOCK;
              end
            end
            LOCK: begin
              // an edge at least 1.5 half-bits after the last one is a mid-bit edge
              if (dedge && (mcnt_inc >= thr)) begin
                sd_dsd_d    = dsd_s;
                sd_strobe_d = 1'b1;
                mcnt_d      = '0;
              end else if (mcnt_inc >= lim) begin
                err_set = 1'b1;
                st_d    = HUNT;
              end
            end
          endcase
        end
      endcase
    end

    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsd_sync_q  <= '0;
      clk_sync_q  <= '0;
      dsd_dly_q   <= 1'b0;
      clk_dly_q   <= 1'b0;
      mode_q      <= MODE_SDCLK_RISE;
      st_q        <= HUNT;
      pend_q      <= 1'b0;
      pend_dat_q  <= 1'b0;
      divcnt_q    <= '0;
      clkgen_q    <= 1'b0;
      mcnt_q      <= '0;
      sd_dsd_q    <= 1'b0;
      sd_strobe_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      dsd_sync_q  <= dsd_sync_d;
      clk_sync_q  <= clk_sync_d;
      dsd_dly_q   <= dsd_dly_d;
      clk_dly_q   <= clk_dly_d;
      mode_q      <= mode_d;
      st_q        <= st_d;
      pend_q      <= pend_d;
      pend_dat_q  <= pend_dat_d;
      divcnt_q    <= divcnt_d;
      clkgen_q    <= clkgen_d;
      mcnt_q      <= mcnt_d;
      sd_dsd_q    <= sd_dsd_d;
      sd_strobe_q <= sd_strobe_d;
      err_q       <= err_d;
    end
  end

  assign sd_dsd     = sd_dsd_q;
  assign sd_strobe  = sd_strobe_q;
  assign sd_clk_out = clkgen_q;
  assign err_manch  = err_q;

endmodule

// File: rtl/icu_mc.sv
// Multi-channel input control unit: NCH independent icu_channel instances,
// each fed from its slice of the packed configuration vectors.
//   SYSCLK, SYSRSTn : system clock, asynchronous active-low reset
//   bus             : pins, configuration and per-channel outputs
module icu_mc
  import sdfm_icu_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned DIV_W       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic     SYSCLK,
  input  logic     SYSRSTn,
  icu_mc_if.slave  bus
);

  logic [NCH-1:0] sd_dsd_w, sd_strobe_w, sd_clk_out_w, err_manch_w;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    icu_channel #(
      .DIV_W       (DIV_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk        (SYSCLK),
      .rst_n      (SYSRSTn),
      .dsdin      (bus.DSDIN[i]),
      .sdclk      (bus.SDCLK[i]),
      .mode       (bus.reg_inmode[2*i +: 2]),
      .clkdiv     (bus.reg_clkdiv[DIV_W*i +: DIV_W]),
      .err_clr    (bus.err_clr[i]),
      .sd_dsd     (sd_dsd_w[i]),
      .sd_strobe  (sd_strobe_w[i]),
      .sd_clk_out (sd_clk_out_w[i]),
      .err_manch  (err_manch_w[i])
    );
  end

  assign bus.sd_dsd     = sd_dsd_w;
  assign bus.sd_strobe  = sd_strobe_w;
  assign bus.sd_clk_out = sd_clk_out_w;
  assign bus.err_manch  = err_manch_w;

endmodule

// File: doc/icu_mc.md
Name: icu_mc

Overview:
- Multi-channel input control unit for the sigma-delta filter front end; one independent channel per modulator.
- Each channel synchronises its raw DSDIN/SDCLK pins into SYSCLK and implements all four input modes: SDCLK rising, SDCLK falling, Manchester-encoded data, internally generated clock.
- Output is a per-channel one-cycle sample strobe with a data bit, feeding the downstream filter chain.
- Also drives an optional modulator clock and a sticky Manchester error flag.

Parameters:
- NCH, 4, number of channels.
- DIV_W, 4, width of each channel's clkdiv field.
- SYNC_STAGES, 2, flops in each input synchroniser (minimum 2).

Ports:
- SYSCLK  in  1  system clock; all logic on rising edge.
- SYSRSTn  in  1  asynchronous active-low reset.
- DSDIN  in  NCH  raw data stream per channel (asynchronous).
- SDCLK  in  NCH  raw modulator clock per channel (asynchronous; unused in modes 2/3).
- reg_inmode  in  2*NCH  mode per channel, channel i at [2i+1:2i].
- reg_clkdiv  in  DIV_W*NCH  divider/half-bit value D per channel.
- err_clr  in  NCH  one-cycle clear of err_manch.
- sd_dsd  out  NCH  sampled data bit, valid with sd_strobe.
- sd_strobe  out  NCH  one-SYSCLK sample-valid pulse.
- sd_clk_out  out  NCH  generated modulator clock (mode 3), else 0.
- err_manch  out  NCH  sticky Manchester loss-of-lock flag.

Behaviour:
- Reset: all outputs 0, synchronisers 0, counters 0, Manchester FSM in HUNT.
- Synchronisers:
  - dsd_s and clk_s are DSDIN/SDCLK after SYNC_STAGES flops.
  - dsd_d and clk_d are each delayed one further cycle.
  - rise = clk_s & ~clk_d; fall = ~clk_s & clk_d; dedge = dsd_s ^ dsd_d.
- Outputs: sd_dsd and sd_strobe are registered. sd_strobe is high for exactly one cycle per accepted sample, and at most once per cycle.
- Mode 00:
  - On rise: sd_dsd <= dsd_d, sd_strobe <= 1 the next cycle.
  - Latency: SYNC_STAGES+2 cycles from the first SYSCLK edge that samples the new SDCLK level.
- Mode 01: identical to mode 00, using fall.
- Mode 11 (internal clock):
  - divcnt increments each cycle. When divcnt >= D, divcnt <= 0 and sd_clk_out toggles.
  - Generated clock period is 2*(D+1) cycles; D=0 gives SYSCLK/2.
  - On each 0->1 toggle: sd_dsd <= dsd_s, sd_strobe <= 1, in the same register update as the toggle.
  - A change of D takes effect at the next compare; the >= compare prevents counter wrap.
  - In all other modes, divcnt and sd_clk_out are held at 0.
- Mode 10 (Manchester, rising mid-bit transition = 1):
  - Half-bit H = D+1 cycles; accept threshold T = H + (H>>1); timeout L = 2H + (H>>1).
  - mcnt counts cycles since the last accepted edge and saturates at all-ones.
  - HUNT state:
    - The first dedge is accepted: sd_dsd <= dsd_s, strobe, mcnt <= 0, go to LOCK.
    - The transmitter sends an alternating-bit preamble so that the first edge is a mid-bit edge.
  - LOCK state:
    - dedge with mcnt+1 >= T: accept the edge (emit a bit as above), mcnt <= 0.
    - dedge with mcnt+1 < T: bit-boundary edge, ignored; mcnt keeps counting.
    - mcnt reaches L: err_manch <= 1, go to HUNT, no strobe.
- err_manch:
  - Set only in mode 10; cleared by err_clr.
  - If set and clear occur in the same cycle, set wins.
  - Value is held across mode changes.
- Mode change:
  - The registered mode is compared with reg_inmode. On a difference, the channel clears divcnt, mcnt and sd_clk_out, and returns to HUNT.
  - sd_strobe is suppressed for that cycle; the new mode runs from the following cycle.
- Channels are fully independent; there is no cross-channel timing relation.
- Reset asserted mid-operation: every output returns to 0 immediately (asynchronously).

Decomposition:
- Package sdfm_icu_pkg holds:
  - mode constants MODE_SDCLK_RISE=2'b00, MODE_SDCLK_FALL=2'b01, MODE_MANCH=2'b10, MODE_INTCLK=2'b11;
  - Manchester FSM state encodings HUNT/LOCK;
  - the minimum SYNC_STAGES value.
- Sub-module icu_channel (parameters DIV_W, SYNC_STAGES) contains one complete channel.
- icu_mc is a generate loop over NCH instances that slices the packed configuration vectors.

Test Plan:
- Mode 00, ch0: SDCLK 8-cycle period, DSDIN pattern 1,0,1,1 stable around rising edges -> strobes every 8 cycles, sd_dsd 1,0,1,1; first strobe at SYNC_STAGES+2 cycles after the edge; other channels silent.
- Mode 01, same stimulus with data stable around falling edges -> strobes aligned to falling edges with matching data; no strobe on rising edges.
- Mode 11, D=3: sd_clk_out period 8 cycles, a strobe at every 0->1 toggle carrying dsd_s. Switch D to 0 mid-run -> period becomes 2 cycles from the next compare, with no glitch shorter than 1 cycle.
- Mode 10, D=3 (H=4, T=6, L=10): preamble 1010 then data 1,1,0,0 at bit time 8 -> bits 1,0,1,0,1,1,0,0 emitted; boundary edges ignored; err_manch stays 0.
- Mode 10 lock loss: stop DSDIN edges after lock -> err_manch=1 exactly 10 cycles after the last accepted edge, FSM in HUNT. err_clr pulse -> flag 0. Set and clr in the same cycle -> flag 1.
- Mode change 11->00 while sd_clk_out=1 -> sd_clk_out 0 the next cycle, no strobe that cycle. SYSRSTn pulse mid-stream -> all outputs 0 asynchronously.
